// File: rtl/program_loader.sv
// Byte-stream program loader: frames SYNC, LEN, 4*LEN little-endian data bytes into instruction-RAM writes.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int         ADDR_W      = 6,
  parameter logic [7:0] SYNC_BYTE   = 8'h55,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int         TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [8:0] MAX_WORDS = 9'(2 ** ADDR_W);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE} state_t;

  state_t            state, state_next;
  logic              accept;
  logic              timeout_hit;
  logic              last_byte;
  logic              set_err;
  logic [TW-1:0]     tcnt;
  logic [1:0]        byte_cnt;
  logic [7:0]        words_left;
  logic [ADDR_W-1:0] word_idx;
  logic [23:0]       shift;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk;
`endif

  assign accept      = in_valid && in_ready;
  assign timeout_hit = (tcnt == T_LAST) && !accept;
  assign last_byte   = (byte_cnt == 2'd3) && (words_left == 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    set_err    = 1'b0;
    case (state)
      S_IDLE: if (accept && in_data == SYNC_BYTE) state_next = S_LEN;
      S_LEN: begin
        if (accept) begin
          if (in_data == 8'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_next = S_CHK;
`else
            state_next = S_DONE;
`endif
          end else if ({1'b0, in_data} > MAX_WORDS) begin
            state_next = S_IDLE;
            set_err    = 1'b1;
          end else begin
            state_next = S_DATA;
          end
        end else if (timeout_hit) begin
          state_next = S_IDLE;
          set_err    = 1'b1;
        end
      end
      S_DATA: begin
        if (accept) begin
          if (last_byte) begin
`ifdef LOADER_CHECKSUM_EN
            state_next = S_CHK;
`else
            state_next = S_DONE;
`endif
          end
        end else if (timeout_hit) begin
          state_next = S_IDLE;
          set_err    = 1'b1;
        end
      end
      S_CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (accept) begin
          if (in_data == chk) begin
            state_next = S_DONE;
          end else begin
            state_next = S_IDLE;
            set_err    = 1'b1;
          end
        end else if (timeout_hit) begin
          state_next = S_IDLE;
          set_err    = 1'b1;
        end
`else
        state_next = S_IDLE;
`endif
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: word assembly, write strobe, status flags and the inter-byte idle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      tcnt       <= '0;
      byte_cnt   <= '0;
      words_left <= '0;
      word_idx   <= '0;
      shift      <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk        <= '0;
`endif
    end else begin
      in_ready  <= (state_next != S_DONE);
      mem_we    <= 1'b0;
      load_done <= (state_next == S_DONE);
      if (state_next == S_DONE) cpu_hold <= 1'b0;
      if (set_err) load_err <= 1'b1;

      if ((state == S_LEN || state == S_DATA || state == S_CHK) && !accept)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;

      if (state == S_IDLE && accept && in_data == SYNC_BYTE) begin
        cpu_hold <= 1'b1;
        load_err <= 1'b0;
        word_idx <= '0;
        byte_cnt <= '0;
      end

      if (state == S_LEN && accept) begin
        words_left <= in_data;
`ifdef LOADER_CHECKSUM_EN
        chk        <= in_data;
`endif
      end

      if (state == S_DATA && accept) begin
`ifdef LOADER_CHECKSUM_EN
        chk      <= chk ^ in_data;
`endif
        shift    <= {in_data, shift[23:8]};
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          mem_we     <= 1'b1;
          mem_addr   <= word_idx;
          mem_wdata  <= {in_data, shift};
          word_idx   <= word_idx + 1'b1;
          words_left <= words_left - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; honours LOADER_CHECKSUM_EN like the design.
module tb_program_loader;

  localparam int T_CYC = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  run_xor;

  logic [5:0]  wr_addr [256];
  logic [31:0] wr_data [256];
  int          wr_n = 0;
  int          done_n = 0;
  logic        hold_at_done = 1'b1;

  int          base_w;
  int          base_d;

  program_loader #(.ADDR_W(6), .SYNC_BYTE(8'h55), .TIMEOUT_CYC(T_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Records every RAM write and done pulse so the main sequence can inspect them later.
  always @(negedge clk) begin
    if (mem_we && wr_n < 256) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_wdata;
      wr_n++;
    end
    if (load_done) begin
      done_n++;
      hold_at_done = cpu_hold;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_output("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    run_xor  = run_xor ^ b;
  endtask

  task automatic send_header(input logic [7:0] len);
    apply_stimulus(8'h55);
    run_xor = 8'h00;
    apply_stimulus(len);
  endtask

  task automatic send_word(input logic [31:0] w);
    apply_stimulus(w[7:0]);
    apply_stimulus(w[15:8]);
    apply_stimulus(w[23:16]);
    apply_stimulus(w[31:24]);
  endtask

  task automatic send_checksum();
`ifdef LOADER_CHECKSUM_EN
    apply_stimulus(run_xor);
`endif
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    base_w = wr_n;
    base_d = done_n;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    run_xor  = 8'h00;
    #12;
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check_output("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_output("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
    check_output("rst_mem_wdata", mem_wdata, 32'd0);
    check_output("rst_load_done", {31'd0, load_done}, 32'd0);
    check_output("rst_load_err", {31'd0, load_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] single-word frame");
    mark();
    send_header(8'h01);
    send_word(32'h12345678);
    send_checksum();
    settle();
    check_output("t1_writes", wr_n - base_w, 32'd1);
    check_output("t1_addr", {26'd0, wr_addr[base_w]}, 32'd0);
    check_output("t1_data", wr_data[base_w], 32'h12345678);
    check_output("t1_done", done_n - base_d, 32'd1);
    check_output("t1_hold_at_done", {31'd0, hold_at_done}, 32'd0);
    check_output("t1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check_output("t1_err", {31'd0, load_err}, 32'd0);

    $display("[TB] three-word frame with sync byte inside data");
    mark();
    apply_stimulus(8'h55);
    check_output("t2_hold_on_sync", {31'd0, cpu_hold}, 32'd1);
    run_xor = 8'h00;
    apply_stimulus(8'h03);
    send_word(32'h11223344);
    send_word(32'h55AA0155);
    send_word(32'hDEADBEEF);
    send_checksum();
    settle();
    check_output("t2_writes", wr_n - base_w, 32'd3);
    check_output("t2_addr0", {26'd0, wr_addr[base_w]}, 32'd0);
    check_output("t2_data0", wr_data[base_w], 32'h11223344);
    check_output("t2_addr1", {26'd0, wr_addr[base_w+1]}, 32'd1);
    check_output("t2_data1", wr_data[base_w+1], 32'h55AA0155);
    check_output("t2_addr2", {26'd0, wr_addr[base_w+2]}, 32'd2);
    check_output("t2_data2", wr_data[base_w+2], 32'hDEADBEEF);
    check_output("t2_done", done_n - base_d, 32'd1);

    $display("[TB] oversize length");
    mark();
    send_header(8'h41);
    settle();
    check_output("t3_writes", wr_n - base_w, 32'd0);
    check_output("t3_err", {31'd0, load_err}, 32'd1);
    check_output("t3_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check_output("t3_done", done_n - base_d, 32'd0);
    apply_stimulus(8'h55);
    run_xor = 8'h00;
    check_output("t3_err_cleared", {31'd0, load_err}, 32'd0);
    apply_stimulus(8'h00);
    send_checksum();
    settle();
    check_output("t3_n0_writes", wr_n - base_w, 32'd0);
    check_output("t3_n0_done", done_n - base_d, 32'd1);
    check_output("t3_n0_hold", {31'd0, cpu_hold}, 32'd0);

    $display("[TB] full 64-word frame");
    mark();
    send_header(8'h40);
    for (int i = 0; i < 64; i++) send_word(32'hC0DE0000 | i);
    send_checksum();
    settle();
    check_output("t64_writes", wr_n - base_w, 32'd64);
    check_output("t64_first_addr", {26'd0, wr_addr[base_w]}, 32'd0);
    check_output("t64_last_addr", {26'd0, wr_addr[base_w+63]}, 32'd63);
    check_output("t64_last_data", wr_data[base_w+63], 32'hC0DE003F);
    check_output("t64_done", done_n - base_d, 32'd1);
    check_output("t64_err", {31'd0, load_err}, 32'd0);

    $display("[TB] idle timeout inside a word");
    mark();
    send_header(8'h01);
    apply_stimulus(8'hAA);
    apply_stimulus(8'hBB);
    repeat (T_CYC - 1) @(posedge clk);
    #1;
    check_output("t4_err_before", {31'd0, load_err}, 32'd0);
    @(posedge clk);
    #1;
    check_output("t4_err_at", {31'd0, load_err}, 32'd1);
    settle();
    check_output("t4_writes", wr_n - base_w, 32'd0);
    check_output("t4_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check_output("t4_done", done_n - base_d, 32'd0);
    apply_stimulus(8'hCC);
    check_output("t4_nonsync_keeps_err", {31'd0, load_err}, 32'd1);

    $display("[TB] reset mid-frame");
    send_header(8'h01);
    apply_stimulus(8'h01);
    apply_stimulus(8'h02);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("t5_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("t5_mem_addr", {26'd0, mem_addr}, 32'd0);
    check_output("t5_mem_wdata", mem_wdata, 32'd0);
    check_output("t5_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check_output("t5_err", {31'd0, load_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mark();
    send_header(8'h02);
    send_word(32'hA1B2C3D4);
    send_word(32'h0F0E0D0C);
    send_checksum();
    settle();
    check_output("t5_writes", wr_n - base_w, 32'd2);
    check_output("t5_data1", wr_data[base_w+1], 32'h0F0E0D0C);
    check_output("t5_addr1", {26'd0, wr_addr[base_w+1]}, 32'd1);
    check_output("t5_done", done_n - base_d, 32'd1);

    $display("[TB] byte arriving on the timeout cycle");
    mark();
    send_header(8'h01);
    apply_stimulus(8'h10);
    apply_stimulus(8'h20);
    apply_stimulus(8'h30);
    repeat (T_CYC - 1) @(posedge clk);
    apply_stimulus(8'h40);
    send_checksum();
    settle();
    check_output("tb_writes", wr_n - base_w, 32'd1);
    check_output("tb_data", wr_data[base_w], 32'h40302010);
    check_output("tb_err", {31'd0, load_err}, 32'd0);
    check_output("tb_done", done_n - base_d, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] checksum good and bad");
    mark();
    send_header(8'h01);
    send_word(32'h00000001);
    apply_stimulus(8'h00);
    settle();
    check_output("t6_good_done", done_n - base_d, 32'd1);
    check_output("t6_good_err", {31'd0, load_err}, 32'd0);
    mark();
    send_header(8'h01);
    send_word(32'h00000001);
    apply_stimulus(8'hFF);
    settle();
    check_output("t6_bad_done", done_n - base_d, 32'd0);
    check_output("t6_bad_err", {31'd0, load_err}, 32'd1);
    check_output("t6_bad_hold", {31'd0, cpu_hold}, 32'd1);
    check_output("t6_bad_writes", wr_n - base_w, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
